// File: rtl/cmd_word_assembler.sv
// cmd_word_assembler: packs received byte pairs into 16-bit motor command words with inter-byte timeout
module cmd_word_assembler #(
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_rdy,
  output logic        timeout_err,
  output logic [7:0]  err_count
);
  typedef enum logic {IDLE, HAVE_HI} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TO_EN = TIMEOUT_CYCLES > 0;
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic [7:0] r_hi, r_err_count;
  logic [15:0] r_cmd_data;
  logic r_cmd_valid, r_timeout_err;
  logic w_rx_ready, w_byte_acc, w_load, w_expire;
  assign rx_ready    = w_rx_ready;
  assign cmd_data    = r_cmd_data;
  assign cmd_valid   = r_cmd_valid;
  assign timeout_err = r_timeout_err;
  assign err_count   = r_err_count;
  // next state: the low byte is back-pressured only while the output word cannot drain;
  // the timer runs only while the sender could have delivered a byte
  always_comb begin
    w_rx_ready  = (r_state == IDLE) | ~r_cmd_valid | cmd_rdy;
    w_byte_acc  = rx_valid & w_rx_ready;
    w_load      = (r_state == HAVE_HI) & w_byte_acc;
    w_expire    = TO_EN & (r_state == HAVE_HI) & w_rx_ready & ~w_byte_acc & (r_timer == LAST);
    w_state_nxt = (r_state == IDLE) ? (w_byte_acc ? HAVE_HI : IDLE) : ((w_load | w_expire) ? IDLE : HAVE_HI);
    w_timer_nxt = ((r_state == IDLE) | w_expire) ? '0 : (TO_EN & w_rx_ready & ~w_byte_acc) ? r_timer + 1'b1 : r_timer;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // datapath: high byte capture, output word register, timer and fault reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi          <= '0;
      r_timer       <= '0;
      r_cmd_data    <= '0;
      r_cmd_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_count   <= '0;
    end else begin
      if (r_state == IDLE && w_byte_acc) r_hi <= rx_data;
      r_timer <= w_timer_nxt;
      if (w_load) r_cmd_data <= {r_hi, rx_data};
      r_cmd_valid   <= w_load | (r_cmd_valid & ~cmd_rdy);
      r_timeout_err <= w_expire;
      if (w_expire && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_cmd_word_assembler.sv
// tb_cmd_word_assembler: directed checks of byte pairing, back-pressure, timeout and reset
module tb_cmd_word_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic [15:0] cmd_data;
  logic cmd_valid;
  logic cmd_rdy = 1'b0;
  logic timeout_err;
  logic [7:0] err_count;
  int total = 0;
  int bad = 0;
  cmd_word_assembler #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy),
    .timeout_err(timeout_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ecnt", err_count, 0);
    rst = 1'b0;
    cmd_rdy = 1'b1;
    send(8'h12);
    rx_data = 8'h34;
    rx_valid = 1'b1;
    chk("basic_rdy", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    chk("basic_valid", cmd_valid, 1);
    chk("basic_data", cmd_data, 16'h1234);
    tick();
    chk("basic_drop", cmd_valid, 0);
    cmd_rdy = 1'b0;
    send(8'hAB);
    send(8'hCD);
    chk("bp_valid", cmd_valid, 1);
    chk("bp_data", cmd_data, 16'hABCD);
    chk("bp_hi_rdy", rx_ready, 1);
    send(8'h01);
    rx_data = 8'h02;
    rx_valid = 1'b1;
    chk("bp_lo_blocked", rx_ready, 0);
    tick();
    tick();
    chk("bp_hold_data", cmd_data, 16'hABCD);
    chk("bp_hold_valid", cmd_valid, 1);
    chk("bp_still_blocked", rx_ready, 0);
    cmd_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    chk("bp_nobubble_valid", cmd_valid, 1);
    chk("bp_next_data", cmd_data, 16'h0102);
    tick();
    chk("bp_drained", cmd_valid, 0);
    send(8'h55);
    for (int i = 0; i < 7; i++) begin
      chk("to_early", timeout_err, 0);
      tick();
    end
    chk("to_pre", timeout_err, 0);
    tick();
    chk("to_pulse", timeout_err, 1);
    chk("to_count", err_count, 1);
    tick();
    chk("to_pulse_end", timeout_err, 0);
    send(8'h66);
    send(8'h77);
    chk("to_after_valid", cmd_valid, 1);
    chk("to_after_data", cmd_data, 16'h6677);
    tick();
    send(8'h88);
    for (int i = 0; i < 7; i++) tick();
    send(8'h99);
    chk("race_valid", cmd_valid, 1);
    chk("race_data", cmd_data, 16'h8899);
    chk("race_terr", timeout_err, 0);
    tick();
    chk("race_terr2", timeout_err, 0);
    chk("race_count", err_count, 1);
    cmd_rdy = 1'b0;
    send(8'hA1);
    send(8'hA2);
    send(8'hB1);
    for (int i = 0; i < 50; i++) begin
      chk("frz_terr", timeout_err, 0);
      chk("frz_rdy", rx_ready, 0);
      tick();
    end
    chk("frz_count", err_count, 1);
    chk("frz_hold", cmd_data, 16'hA1A2);
    cmd_rdy = 1'b1;
    send(8'hB2);
    chk("frz_valid", cmd_valid, 1);
    chk("frz_data", cmd_data, 16'hB1B2);
    tick();
    send(8'h11);
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy", rx_ready, 1);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_data", cmd_data, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_ecnt", err_count, 0);
    rst = 1'b0;
    send(8'h22);
    send(8'h33);
    chk("mid_after_valid", cmd_valid, 1);
    chk("mid_after_data", cmd_data, 16'h2233);
    chk("mid_after_ecnt", err_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
